approx_error_monitor: RTL and testbench

Streaming error-metrics collector placed directly downstream of the hybrid approximate adder. Each accepted sample carries the operand pair A, B and the adder's approximate {cout, sum}. The block recomputes the exact N+1-bit sum and measures the error distance. Over a programmable window of samples it accumulates error count, summed error distance (ED) and maximum ED, giving the figures used to characterise each N1/N2 split in hardware.

---
 rtl/approx_error_monitor_pkg.sv | 16 +
 rtl/approx_error_monitor_abs_diff.sv | 20 ++
 rtl/approx_error_monitor.sv | 187 ++++++++++++++++++
 tb/tb_approx_error_monitor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_error_monitor_pkg.sv
// Shared definitions for the approximate-adder error monitor: the default
// widths used by the adder benches and the monitor state encoding.
package approxMonitorPkg;

   localparam int DEF_N     = 32;
   localparam int DEF_CNT_W = 32;
   localparam int DEF_ACC_W = 48;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mon_state_e;

endpackage

// File: rtl/approx_error_monitor_abs_diff.sv
// Combinational unsigned absolute difference |x - y| for a given width.
module absDiff #(
   parameter int W = 33
)(
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] d
);

   // Subtract the smaller operand from the larger so the result never wraps.
   always_comb begin
      d = {W{1'b0}};
      if (x >= y) begin
         d = x - y;
      end else begin
         d = y - x;
      end
   end

endmodule

// File: rtl/approx_error_monitor.sv
// Streaming error-metrics collector for the hybrid approximate adder.
// Samples flow through two register stages (S1: exact/approx, S2: error
// distance) before being folded into the window statistics.
module approx_error_monitor
   import approxMonitorPkg::*;
#(
   parameter int N     = DEF_N,
   parameter int CNT_W = DEF_CNT_W,
   parameter int ACC_W = DEF_ACC_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] window_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     A,
   input  logic [N-1:0]     B,
   input  logic [N-1:0]     approx_sum,
   input  logic             approx_cout,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [ACC_W-1:0] ed_sum,
   output logic [N:0]       ed_max
);

   localparam int EW = N + 1;
   // Sum width wide enough for either operand plus a carry, so ED wider
   // than the accumulator still saturates correctly.
   localparam int SW = ((ACC_W > EW) ? ACC_W : EW) + 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   mon_state_e       state_r, next_state_s;
   logic [CNT_W-1:0] len_q_r, len_next_s;
   logic [CNT_W-1:0] issued_r, issued_next_s;
   logic             in_ready_r, busy_r, done_r;
   logic             start_ok_s, xfer_s;

   logic             s1_valid_r;
   logic [EW-1:0]    s1_exact_r, s1_approx_r;
   logic             s2_valid_r;
   logic [EW-1:0]    s2_ed_r, ed_s;

   logic [CNT_W-1:0] sample_cnt_r, err_cnt_r;
   logic [ACC_W-1:0] ed_sum_r, ed_sum_next_s;
   logic [EW-1:0]    ed_max_r;
   logic [SW-1:0]    sum_ext_s;

   assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
   assign xfer_s     = in_valid && in_ready_r && (state_r == RUN);

   // Next-state, issue counter and window length selection.
   always_comb begin
      next_state_s  = state_r;
      issued_next_s = issued_r;
      len_next_s    = len_q_r;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               len_next_s    = window_len;
               issued_next_s = CNT_ZERO;
               if (window_len == CNT_ZERO) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = RUN;
               end
            end else begin
               next_state_s = state_r;
            end
         end
         RUN: begin
            if (xfer_s) begin
               issued_next_s = issued_r + CNT_ONE;
               if (issued_next_s == len_q_r) begin
                  next_state_s = DRAIN;
               end else begin
                  next_state_s = RUN;
               end
            end else begin
               next_state_s = RUN;
            end
         end
         DRAIN: begin
            if (!s1_valid_r && !s2_valid_r) begin
               next_state_s = DONE;
            end else begin
               next_state_s = DRAIN;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, counters and the registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         len_q_r    <= CNT_ZERO;
         issued_r   <= CNT_ZERO;
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         len_q_r    <= len_next_s;
         issued_r   <= issued_next_s;
         in_ready_r <= (next_state_s == RUN) && (issued_next_s < len_next_s);
         busy_r     <= (next_state_s == RUN) || (next_state_s == DRAIN);
         done_r     <= (next_state_s == DONE);
      end
   end

   // S1: capture exact and approximate sums of each transferred sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_exact_r  <= {EW{1'b0}};
         s1_approx_r <= {EW{1'b0}};
      end else begin
         s1_valid_r <= xfer_s;
         if (xfer_s) begin
            s1_exact_r  <= {1'b0, A} + {1'b0, B};
            s1_approx_r <= {approx_cout, approx_sum};
         end
      end
   end

   absDiff #(.W(EW)) u_abs_diff (
      .x (s1_exact_r),
      .y (s1_approx_r),
      .d (ed_s)
   );

   // S2: register the error distance of the sample leaving S1.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         s2_ed_r    <= {EW{1'b0}};
      end else begin
         s2_valid_r <= s1_valid_r;
         s2_ed_r    <= ed_s;
      end
   end

   // Saturating accumulation: any carry beyond ACC_W bits pins the sum high.
   always_comb begin
      sum_ext_s = SW'(ed_sum_r) + SW'(s2_ed_r);
      if ((sum_ext_s >> ACC_W) != {SW{1'b0}}) begin
         ed_sum_next_s = {ACC_W{1'b1}};
      end else begin
         ed_sum_next_s = sum_ext_s[ACC_W-1:0];
      end
   end

   // Window statistics: cleared on an accepted start, updated per retired sample.
   always_ff @(posedge clk) begin
      if (rst || start_ok_s) begin
         sample_cnt_r <= CNT_ZERO;
         err_cnt_r    <= CNT_ZERO;
         ed_sum_r     <= {ACC_W{1'b0}};
         ed_max_r     <= {EW{1'b0}};
      end else if (s2_valid_r) begin
         sample_cnt_r <= sample_cnt_r + CNT_ONE;
         if (s2_ed_r != {EW{1'b0}}) begin
            err_cnt_r <= err_cnt_r + CNT_ONE;
         end
         ed_sum_r <= ed_sum_next_s;
         if (s2_ed_r > ed_max_r) begin
            ed_max_r <= s2_ed_r;
         end
      end
   end

   assign in_ready   = in_ready_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign sample_cnt = sample_cnt_r;
   assign err_cnt    = err_cnt_r;
   assign ed_sum     = ed_sum_r;
   assign ed_max     = ed_max_r;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Scoreboard bench for approx_error_monitor: stimulus pushes expected window
// statistics; monitors compare them when done is presented.
module tb_approx_error_monitor;

   typedef struct {
      logic [63:0] sc;
      logic [63:0] ec;
      logic [63:0] sum;
      logic [63:0] mx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // 32-bit default instance
   logic        start = 1'b0;
   logic [31:0] window_len = 32'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] A = 32'd0, B = 32'd0, approx_sum = 32'd0;
   logic        approx_cout = 1'b0;
   logic        busy, done;
   logic [31:0] sample_cnt, err_cnt;
   logic [47:0] ed_sum;
   logic [32:0] ed_max;

   // N=8, ACC_W=8 instance for saturation
   logic        start8 = 1'b0;
   logic [31:0] window_len8 = 32'd0;
   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [7:0]  a8 = 8'd0, b8 = 8'd0, approx_sum8 = 8'd0;
   logic        approx_cout8 = 1'b0;
   logic        busy8, done8;
   logic [31:0] sample_cnt8, err_cnt8;
   logic [7:0]  ed_sum8;
   logic [8:0]  ed_max8;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   exp_t exp8_q[$];
   int   cyc = 0;
   int   xfer_cnt = 0;
   int   last_xfer = 0;
   int   done_rise_edge = 0;
   logic done_d = 1'b0, start_d = 1'b0;
   logic done8_d = 1'b0, start8_d = 1'b0;

   approx_error_monitor dut (
      .clk(clk), .rst(rst), .start(start), .window_len(window_len),
      .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
      .approx_sum(approx_sum), .approx_cout(approx_cout),
      .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
      .ed_sum(ed_sum), .ed_max(ed_max)
   );

   approx_error_monitor #(.N(8), .CNT_W(32), .ACC_W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .window_len(window_len8),
      .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8),
      .approx_sum(approx_sum8), .approx_cout(approx_cout8),
      .busy(busy8), .done(done8), .sample_cnt(sample_cnt8), .err_cnt(err_cnt8),
      .ed_sum(ed_sum8), .ed_max(ed_max8)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Edge bookkeeping: cycle index, transfers seen, start accepted last edge.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      start_d  <= start & ~rst;
      start8_d <= start8 & ~rst;
      if (in_valid && in_ready && !rst) begin
         xfer_cnt  <= xfer_cnt + 1;
         last_xfer <= cyc;
      end
   end

   // Monitor for the 32-bit instance: compare statistics when done is presented.
   always @(negedge clk) begin
      if (done && (!done_d || start_d)) begin
         done_rise_edge = cyc - 1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1 expected no window pending");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sample_cnt", 64'(sample_cnt), e.sc);
            check("err_cnt",    64'(err_cnt),    e.ec);
            check("ed_sum",     64'(ed_sum),     e.sum);
            check("ed_max",     64'(ed_max),     e.mx);
         end
      end
      done_d = done;
   end

   // Monitor for the narrow instance.
   always @(negedge clk) begin
      if (done8 && (!done8_d || start8_d)) begin
         if (exp8_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done8: got done=1 expected no window pending");
         end else begin
            exp_t e;
            e = exp8_q.pop_front();
            check("sample_cnt8", 64'(sample_cnt8), e.sc);
            check("err_cnt8",    64'(err_cnt8),    e.ec);
            check("ed_sum8",     64'(ed_sum8),     e.sum);
            check("ed_max8",     64'(ed_max8),     e.mx);
         end
      end
      done8_d = done8;
   end

   task automatic do_start(input logic [31:0] len);
      @(negedge clk);
      start = 1'b1;
      window_len = len;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [32:0] ap);
      int k;
      A = a;
      B = b;
      approx_sum = ap[31:0];
      approx_cout = ap[32];
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("in_ready_for_send", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("done_reached", 64'(done), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_start8(input logic [31:0] len);
      @(negedge clk);
      start8 = 1'b1;
      window_len8 = len;
      @(posedge clk);
      #1;
      start8 = 1'b0;
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ap);
      int k;
      a8 = a;
      b8 = b;
      approx_sum8 = ap[7:0];
      approx_cout8 = ap[8];
      in_valid8 = 1'b1;
      k = 0;
      while (!in_ready8 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("in_ready8_for_send", 64'(in_ready8), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int k;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      // reset state
      check("rst_in_ready",   64'(in_ready),   64'd0);
      check("rst_busy",       64'(busy),       64'd0);
      check("rst_done",       64'(done),       64'd0);
      check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
      check("rst_ed_sum",     64'(ed_sum),     64'd0);
      check("rst_ed_max",     64'(ed_max),     64'd0);

      // exact adder output: no error at all, including carry-out cases
      exp_q.push_back('{64'd4, 64'd0, 64'd0, 64'd0});
      do_start(32'd4);
      send(32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
      send(32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000);
      send(32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789);
      send(32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000);
      in_valid = 1'b0;
      wait_done();

      // approximation always 5 below exact
      exp_q.push_back('{64'd3, 64'd3, 64'd15, 64'd5});
      do_start(32'd3);
      send(32'd100, 32'd50, 33'd145);
      send(32'hFFFF_FFFF, 32'd3, 33'h0_FFFF_FFFD);
      send(32'd7, 32'd0, 33'd2);
      in_valid = 1'b0;
      wait_done();

      // mixed signs of error, MSB-only error: EDs 10, 0, 2^32
      exp_q.push_back('{64'd3, 64'd2, 64'h1_0000_000A, 64'h1_0000_0000});
      do_start(32'd3);
      send(32'd10, 32'd10, 33'd30);
      send(32'd1000, 32'd0, 33'd1000);
      send(32'h8000_0000, 32'h8000_0000, 33'h0_0000_0000);
      in_valid = 1'b0;
      wait_done();

      // zero-length window from DONE: statistics cleared, no in_ready
      exp_q.push_back('{64'd0, 64'd0, 64'd0, 64'd0});
      do_start(32'd0);
      @(negedge clk);
      check("len0_in_ready_a", 64'(in_ready), 64'd0);
      check("len0_done",       64'(done),     64'd1);
      @(negedge clk);
      check("len0_in_ready_b", 64'(in_ready), 64'd0);

      // continuous stream of length 2 with valid held high
      exp_q.push_back('{64'd2, 64'd0, 64'd0, 64'd0});
      do_start(32'd2);
      base = xfer_cnt;
      A = 32'd10;
      B = 32'd20;
      approx_sum = 32'd30;
      approx_cout = 1'b0;
      in_valid = 1'b1;
      wait_done();
      check("stream_xfers", 64'(xfer_cnt - base), 64'd2);
      check("done_latency", 64'(done_rise_edge - last_xfer), 64'd3);
      check("stream_in_ready_low", 64'(in_ready), 64'd0);
      in_valid = 1'b0;

      // saturation on the narrow instance: ED=200 three times
      exp8_q.push_back('{64'd3, 64'd3, 64'd255, 64'd200});
      do_start8(32'd3);
      send8(8'd0, 8'd0, 9'd200);
      send8(8'd100, 8'd100, 9'd0);
      send8(8'd255, 8'd255, 9'd310);
      in_valid8 = 1'b0;
      k = 0;
      while (!done8 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("done8_reached", 64'(done8), 64'd1);
      @(posedge clk);
      #1;

      // abort mid-window: 2 of 10 transferred, rst one cycle later
      do_start(32'd10);
      send(32'd1, 32'd1, 33'd5);
      send(32'd2, 32'd2, 33'd9);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy",       64'(busy),       64'd0);
      check("abort_in_ready",   64'(in_ready),   64'd0);
      check("abort_done",       64'(done),       64'd0);
      check("abort_sample_cnt", 64'(sample_cnt), 64'd0);
      repeat (3) @(negedge clk);
      check("abort_flushed_cnt", 64'(sample_cnt), 64'd0);
      check("abort_flushed_sum", 64'(ed_sum),     64'd0);

      // start together with rst: rst wins
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      window_len = 32'd5;
      @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_beats_start_busy",     64'(busy),     64'd0);
      check("rst_beats_start_in_ready", 64'(in_ready), 64'd0);

      // fresh single-sample window after the abort, ED=1
      exp_q.push_back('{64'd1, 64'd1, 64'd1, 64'd1});
      do_start(32'd1);
      send(32'd5, 32'd5, 33'd11);
      in_valid = 1'b0;
      wait_done();

      repeat (5) @(negedge clk);
      check("scoreboard_drained",  64'(exp_q.size()),  64'd0);
      check("scoreboard8_drained", 64'(exp8_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
